if_fetch_unit: RTL

Instruction-fetch stage sitting directly upstream of the instruction memory IM. It owns the program counter and drives IM's `addr` input. It captures IM's combinational `out` word into a registered fetch slot, together with its PC. The slot is handed to decode over a valid/ready handshake. It also handles control-flow redirects, stalls from decode, and a halt-instruction stop.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/if_fetch_unit_pc_reg.sv | 39 +++
 rtl/if_fetch_unit.sv | 95 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Core-wide constants and the fetch-stage state encoding; decode and the branch
// unit reuse XLEN and HALT_WORD from here.
package cpu_pkg;

  localparam int unsigned       XLEN      = 32;
  localparam logic [XLEN-1:0]   RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0]   PC_STEP   = 32'd4;
  localparam logic [XLEN-1:0]   HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: IM address/data, redirect input, and the decode-facing slot.
// master = fetch unit side, slave = the IM/decode/branch environment.
interface if_fetch_unit_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] im_addr;
  logic [XLEN-1:0] im_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic            halted;
  logic [XLEN-1:0] fetch_count;

  modport master (
    output im_addr, out_valid, out_instr, out_pc, halted, fetch_count,
    input  im_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  im_addr, out_valid, out_instr, out_pc, halted, fetch_count,
    output im_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter: load wins over increment; output is the register itself, so
// the address is valid from the edge that updates it; no backpressure of its own.
module pc_reg #(
  parameter logic [cpu_pkg::XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [cpu_pkg::XLEN-1:0] PC_STEP  = cpu_pkg::PC_STEP
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_i,
  input  logic [cpu_pkg::XLEN-1:0] load_pc_i,
  input  logic                     inc_i,
  output logic [cpu_pkg::XLEN-1:0] pc_o
);
  import cpu_pkg::*;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Sum is taken at XLEN bits so the top of the address space wraps to zero.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: drives IM with the PC, captures the word into a one-entry slot
// one cycle later; decode stalls via out_ready, redirects flush the slot.
module if_fetch_unit #(
  parameter logic [cpu_pkg::XLEN-1:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [cpu_pkg::XLEN-1:0] PC_STEP   = cpu_pkg::PC_STEP,
  parameter logic [cpu_pkg::XLEN-1:0] HALT_WORD = cpu_pkg::HALT_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  if_fetch_unit_if.master       bus
);
  import cpu_pkg::*;

  fetch_state_e    state_q;
  logic            out_valid_q;
  logic            halted_q;
  logic [XLEN-1:0] out_instr_q;
  logic [XLEN-1:0] out_pc_q;
  logic [XLEN-1:0] fetch_count_q;
  logic [XLEN-1:0] pc;

  logic advance;
  logic handshake;
  logic is_halt;
  logic capture;
  logic pc_inc;

  assign advance   = ~out_valid_q | bus.out_ready;
  assign handshake = out_valid_q & bus.out_ready;
  assign is_halt   = (bus.im_rdata == HALT_WORD);
  assign capture   = ~bus.redirect_valid & (state_q == RUN) & advance;
  // A captured halt word is still delivered, but the PC parks on its address.
  assign pc_inc    = capture & ~is_halt;

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (bus.redirect_valid),
    .load_pc_i (bus.redirect_pc),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      out_valid_q   <= 1'b0;
      halted_q      <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      fetch_count_q <= '0;
    end else begin
      // A handshake completing on a redirect edge still counts as delivered.
      fetch_count_q <= fetch_count_q + {{(XLEN-1){1'b0}}, handshake};
      if (bus.redirect_valid) begin
        out_valid_q <= 1'b0;
        state_q     <= RUN;
        halted_q    <= 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            if (advance) begin
              out_instr_q <= bus.im_rdata;
              out_pc_q    <= pc;
              out_valid_q <= 1'b1;
              if (is_halt) begin
                state_q  <= HALTED;
                halted_q <= 1'b1;
              end
            end
          end
          HALTED: begin
            if (bus.out_ready) begin
              out_valid_q <= 1'b0;
            end
          end
          default: begin
            state_q <= RUN;
          end
        endcase
      end
    end
  end

  assign bus.im_addr     = pc;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = out_instr_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = fetch_count_q;

endmodule
